// File: rtl/reg_dump_if.sv
// Debug-read and dump-stream bundle between reg_dump, the register file
// debug port and the word consumer.
interface reg_dump_if #(
    parameter int N = 32
);
    logic [4:0]   checka;
    logic [N-1:0] check;
    logic         dvalid;
    logic         dready;
    logic [4:0]   didx;
    logic [N-1:0] ddata;

    modport master (
        output checka,
        input  check,
        output dvalid,
        input  dready,
        output didx,
        output ddata
    );

    modport slave (
        input  checka,
        output check,
        input  dvalid,
        output dready,
        input  didx,
        input  ddata
    );
endinterface

// File: rtl/reg_dump.sv
// Walks registers 0..L-1 through the debug read port and streams each value
// out over a valid/ready handshake, optionally dropping zero-valued words.
module reg_dump #(
    parameter int N         = 32,
    parameter int L         = 32,
    parameter int SKIP_ZERO = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    reg_dump_if.master rf,
    output logic       busy,
    output logic       done,
    output logic [5:0] count
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(L - 1);

    state_t       state_reg, state_next;
    logic [4:0]   idx_reg, idx_next;
    logic [4:0]   didx_reg, didx_next;
    logic [N-1:0] ddata_reg, ddata_next;
    logic [5:0]   count_reg, count_next;

    logic [N-1:0] fetch_value;
    logic         skip_word;
    logic         handshake;
    logic         last_word;

    // Register 0 is architecturally zero whatever the storage holds.
    assign fetch_value = (idx_reg == 5'd0) ? '0 : rf.check;
    assign skip_word   = (SKIP_ZERO != 0) && (fetch_value == '0);
    assign handshake   = (state_reg == S_SEND) && rf.dready;
    assign last_word   = (idx_reg == LAST_IDX);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        didx_next  = didx_reg;
        ddata_next = ddata_reg;
        count_next = count_reg;

        case (state_reg)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next = S_FETCH;
                    idx_next   = 5'd0;
                    count_next = 6'd0;
                end
            end

            S_FETCH: begin
                ddata_next = fetch_value;
                didx_next  = idx_reg;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (skip_word) begin
                    if (last_word) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next = idx_reg + 5'd1;
                    end
                end else begin
                    state_next = S_SEND;
                end
            end

            S_SEND: begin
                // A word accepted in the same cycle as abort still counts.
                if (handshake) begin
                    count_next = count_reg + 6'd1;
                end
                if (abort) begin
                    state_next = S_IDLE;
                end else if (handshake) begin
                    if (last_word) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next   = idx_reg + 5'd1;
                        state_next = S_FETCH;
                    end
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            idx_reg   <= 5'd0;
            didx_reg  <= 5'd0;
            ddata_reg <= '0;
            count_reg <= 6'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            didx_reg  <= didx_next;
            ddata_reg <= ddata_next;
            count_reg <= count_next;
        end
    end

    assign rf.checka = (state_reg == S_FETCH) ? idx_reg : 5'd0;
    assign rf.dvalid = (state_reg == S_SEND);
    assign rf.didx   = didx_reg;
    assign rf.ddata  = ddata_reg;
    assign busy      = (state_reg == S_FETCH) || (state_reg == S_SEND);
    assign done      = (state_reg == S_DONE);
    assign count     = count_reg;
endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter N, default 32: register data width in bits.
REQ-002 Parameter L, default 32: number of registers scanned; 2 <= L <= 32.
REQ-003 Parameter SKIP_ZERO, default 0: when 1, words whose architectural value is zero are not emitted.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a full register dump.
REQ-007 abort  input  1  terminate the dump in progress.
REQ-008 checka  output  5  register index driven to the register file debug read port.
REQ-009 check  input  N  combinational register file data for checka.
REQ-010 dvalid  output  1  ddata/didx hold a valid dump word.
REQ-011 dready  input  1  consumer accepts the word when dvalid&&dready.
REQ-012 didx  output  5  register index of the presented word.
REQ-013 ddata  output  N  register value of the presented word.
REQ-014 busy  output  1  high from the cycle after an accepted start until the cycle DONE is entered.
REQ-015 done  output  1  one-cycle pulse on completion of a full dump.
REQ-016 count  output  6  number of words handed off in the current or last dump.

Function
REQ-017 The FSM states are IDLE, FETCH, SEND and DONE; an internal index idx (5 bits) selects the register.
REQ-018 IDLE: checka=0, dvalid=0, busy=0; start=1 -> FETCH with idx=0 and count=0.
REQ-019 start is ignored in every state except IDLE.
REQ-020 FETCH: checka=idx; at the clock edge ddata<=check (forced to 0 when idx==0), didx<=idx.
REQ-021 FETCH with SKIP_ZERO=0 -> SEND.
REQ-021a FETCH with SKIP_ZERO=1 and a zero value -> no SEND; the machine advances as if the word were accepted.
REQ-022 SEND: dvalid=1; ddata and didx stay stable until dvalid&&dready.
REQ-023 On handshake in SEND, count increments by 1.
REQ-023a On handshake in SEND, idx==L-1 -> DONE; otherwise idx increments by 1 and the state becomes FETCH.
REQ-024 Skipped word at idx==L-1 -> DONE.
REQ-025 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; count holds until the next accepted start.
REQ-026 Throughput with dready held high: 2 cycles per emitted word; start at edge E0 -> first dvalid in cycle 2.
REQ-026a With dready held high, L=32 and SKIP_ZERO=0, done is high in cycle 65.
REQ-027 abort=1 in any non-IDLE state -> IDLE at the next edge with dvalid=0 and no done pulse; count holds its value.
REQ-028 abort and start asserted together in IDLE: abort has priority and the dump does not start.
REQ-029 abort and a handshake in the same cycle: the word counts as accepted (count increments), and the state still goes to IDLE.
REQ-030 idx never exceeds L-1; the width of count covers L=32 without wrap.

Reset
REQ-031 reset=1 at a clock edge -> IDLE, idx=0, checka=0, dvalid=0, didx=0, ddata=0, busy=0, done=0, count=0.
REQ-032 Reset overrides start, abort and any in-progress handshake; no done pulse is generated.

Verification
REQ-033 rf[i]=i+100 for all i, SKIP_ZERO=0, dready=1, one start pulse -> 32 words idx 0..31, data 0,101..131; done in cycle 65; count=32.
REQ-034 Same load, dready toggled 1-of-3 cycles -> ddata/didx stable while dvalid&&!dready; no word lost or duplicated.
REQ-035 SKIP_ZERO=1 with only rf[5]=7 and rf[31]=9 nonzero -> exactly 2 words (5,7) and (31,9); done pulse; count=2.
REQ-036 abort asserted during SEND of idx 10 with dready=0 -> dvalid low on the next cycle, IDLE, no done, count=10.
REQ-037 start re-pulsed while busy, then reset mid-dump at idx 20 -> the second start has no effect; after reset all outputs are zero.
REQ-038 Register 0 holds garbage 0xDEADBEEF internally -> word idx 0 reports ddata=0.
